// File: rtl/sisc_ctrl.sv
// SISC multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK and
// decodes the instruction latched at DECODE into ALU, status and register-file strobes.
module sisc_ctrl #(
    parameter logic [3:0] OPC_NOP = 4'h0,
    parameter logic [3:0] OPC_ALU = 4'h1,
    parameter logic [3:0] OPC_ALI = 4'h2,
    parameter logic [3:0] OPC_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       rst_f,
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    output logic [1:0] alu_op,
    output logic [3:0] alu_func,
    output logic       stat_en,
    output logic       rf_we,
    output logic       wb_sel,
    output logic       illegal,
    output logic       halt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        START0    = 3'd0,
        START1    = 3'd1,
        FETCH     = 3'd2,
        DECODE    = 3'd3,
        EXECUTE   = 3'd4,
        MEM       = 3'd5,
        WRITEBACK = 3'd6,
        HALT      = 3'd7
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_opc;
    logic [3:0] r_mm;
    logic       w_mm_ok;
    logic       w_alu_legal;
    logic       w_in_exwb;

    always_ff @(posedge clk or posedge rst_f) begin
        if (rst_f) begin
            r_state <= START0;
            r_opc   <= '0;
            r_mm    <= '0;
        end else begin
            r_state <= w_next;
            // Instruction fields are captured once; later input changes are ignored.
            if (r_state == DECODE) begin
                r_opc <= opcode;
                r_mm  <= mm;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            START0:    w_next = START1;
            START1:    w_next = FETCH;
            FETCH:     w_next = DECODE;
            DECODE:    w_next = (opcode == OPC_HLT) ? HALT : EXECUTE;
            EXECUTE:   w_next = MEM;
            MEM:       w_next = WRITEBACK;
            WRITEBACK: w_next = FETCH;
            HALT:      w_next = HALT;
            default:   w_next = START0;
        endcase
    end

    always_comb begin
        w_mm_ok = 1'b0;
        case (r_mm)
            4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h7,
            4'h8, 4'h9, 4'hA, 4'hB: w_mm_ok = 1'b1;
            default:                w_mm_ok = 1'b0;
        endcase
    end

    assign w_alu_legal = ((r_opc == OPC_ALU) || (r_opc == OPC_ALI)) && w_mm_ok;
    assign w_in_exwb   = (r_state == EXECUTE) || (r_state == MEM) || (r_state == WRITEBACK);

    always_comb begin
        alu_op   = 2'b00;
        alu_func = 4'h0;
        stat_en  = 1'b0;
        rf_we    = 1'b0;
        illegal  = 1'b0;
        halt     = 1'b0;
        if (w_in_exwb && w_alu_legal) begin
            alu_op   = {1'b0, (r_opc == OPC_ALI)};
            alu_func = r_mm;
        end
        if (r_state == EXECUTE) begin
            stat_en = w_alu_legal;
            illegal = !w_alu_legal && (r_opc != OPC_NOP);
        end
        if (r_state == WRITEBACK) rf_we = w_alu_legal;
        if (r_state == HALT)      halt  = 1'b1;
    end

    assign wb_sel = 1'b0;
    assign state  = r_state;

endmodule

// File: tb/tb_sisc_ctrl.sv
// Self-checking bench for sisc_ctrl: directed and random instructions checked against
// a cycle-count reference model of the 5-clock instruction sequence.
module tb_sisc_ctrl;

    logic       clk;
    logic       rst_f;
    logic [3:0] opcode;
    logic [3:0] mm;
    logic [1:0] alu_op;
    logic [3:0] alu_func;
    logic       stat_en;
    logic       rf_we;
    logic       wb_sel;
    logic       illegal;
    logic       halt;
    logic [2:0] state;

    int unsigned n_cmp;
    int unsigned n_bad;

    // Reference model: cycles since reset release, halt flag, decoded instruction.
    int unsigned m_n;
    bit          m_halted;
    logic [3:0]  m_op;
    logic [3:0]  m_mm;

    sisc_ctrl dut (
        .clk      (clk),
        .rst_f    (rst_f),
        .opcode   (opcode),
        .mm       (mm),
        .alu_op   (alu_op),
        .alu_func (alu_func),
        .stat_en  (stat_en),
        .rf_we    (rf_we),
        .wb_sel   (wb_sel),
        .illegal  (illegal),
        .halt     (halt),
        .state    (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int unsigned model_state();
        if (m_halted)      return 7;
        else if (m_n == 0) return 0;
        else if (m_n == 1) return 1;
        else               return 2 + ((m_n - 2) % 5);
    endfunction

    function automatic bit model_legal();
        return (m_op == 4'h1 || m_op == 4'h2) && m_mm >= 4'h1 && m_mm <= 4'hB && m_mm != 4'h3;
    endfunction

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_all();
        int unsigned s;
        bit          lg;
        bit          exwb;
        s    = model_state();
        lg   = model_legal();
        exwb = (s >= 4 && s <= 6);
        chk("state",    4'(state),    4'(s));
        chk("alu_op",   4'(alu_op),   (exwb && lg && m_op == 4'h2) ? 4'h1 : 4'h0);
        chk("alu_func", alu_func,     (exwb && lg) ? m_mm : 4'h0);
        chk("stat_en",  4'(stat_en),  4'(s == 4 && lg));
        chk("rf_we",    4'(rf_we),    4'(s == 6 && lg));
        chk("illegal",  4'(illegal),  4'(s == 4 && !lg && m_op != 4'h0));
        chk("halt",     4'(halt),     4'(s == 7));
        chk("wb_sel",   4'(wb_sel),   4'h0);
    endtask

    task automatic model_reset();
        m_n      = 0;
        m_halted = 1'b0;
        m_op     = 4'h0;
        m_mm     = 4'h0;
    endtask

    task automatic step(input logic [3:0] op, input logic [3:0] m);
        opcode = op;
        mm     = m;
        @(posedge clk);
        if (model_state() == 3) begin
            m_op = op;
            m_mm = m;
            if (op == 4'hF) m_halted = 1'b1;
        end
        m_n++;
        #1;
        check_all();
    endtask

    task automatic step_rand();
        step(4'($urandom), 4'($urandom));
    endtask

    task automatic do_reset(input int unsigned cycles);
        rst_f = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (cycles) @(posedge clk);
        #1;
        check_all();
        rst_f = 1'b0;
    endtask

    // Runs one instruction with op/m presented only on the decode edge.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] m);
        int unsigned guard;
        guard = 0;
        while (model_state() != 3 && guard < 10) begin
            step_rand();
            guard++;
        end
        step(op, m);
        guard = 0;
        while (model_state() != 2 && !m_halted && guard < 10) begin
            step_rand();
            guard++;
        end
    endtask

    initial begin
        logic [3:0] op;
        n_cmp  = 0;
        n_bad  = 0;
        rst_f  = 1'b1;
        opcode = 4'h0;
        mm     = 4'h0;
        model_reset();

        do_reset(2);
        run_instr(4'h1, 4'h1);
        run_instr(4'h2, 4'h1);
        run_instr(4'h0, 4'h5);
        run_instr(4'h3, 4'h1);
        run_instr(4'h1, 4'hC);
        run_instr(4'h2, 4'hB);
        run_instr(4'h1, 4'h0);
        run_instr(4'hE, 4'h4);

        repeat (150) begin
            op = 4'($urandom_range(0, 14));
            if ($urandom_range(0, 1) == 1) op = 4'($urandom_range(1, 2));
            run_instr(op, 4'($urandom));
        end

        run_instr(4'hF, 4'h0);
        repeat (20) step(4'h1, 4'h1);
        do_reset(1);

        run_instr(4'h1, 4'h1);
        while (model_state() != 3) step_rand();
        step(4'h1, 4'h1);
        #2;
        rst_f = 1'b1;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_f = 1'b0;
        repeat (12) step_rand();
        run_instr(4'h2, 4'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
